fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised next-generation instruction fetch stage of the RISC-V pipeline.
- Decouples fetch from decode with a FQ_DEPTH-entry fetch queue.
- Talks to instruction memory through a latency-insensitive request/response interface, and accepts branch/jump redirects from decode.
- Adds decode-side backpressure (stall), redirect flush and discard of in-flight stale responses, none of which the current single-register fetch stage supports.

Parameters:
- XLEN, 64, PC and address width.
- RESET_PC, 0, PC value after reset.
- IMEM_AW, 8, instruction-memory word-address width.
- FQ_DEPTH, 4, fetch-queue entries and maximum in-flight requests; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- redirect_valid  in  1  redirect request (branch taken or jal) from decode.
- redirect_pc  in  XLEN  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  IMEM_AW  word address, pc_f[IMEM_AW+1:2].
- imem_rsp_valid  in  1  response valid; responses return in request order.
- imem_rsp_data  in  32  instruction word.
- valid_d  out  1  InstrD/PCD/PCPlus4D hold a valid instruction.
- ready_d  in  1  decode consumes the head entry; low means stall.
- InstrD  out  32  instruction.
- PCD  out  XLEN  PC of InstrD.
- PCPlus4D  out  XLEN  PCD+4.

Behaviour:
- State:
  - pc_f, the next PC to request.
  - Fetch queue of {pc, instr}.
  - pc FIFO of outstanding request PCs, depth FQ_DEPTH.
  - out_cnt: outstanding requests, live and stale.
  - drop_cnt: stale responses still to discard.
  - Counter widths are clog2(FQ_DEPTH+1).
- Reset (asynchronous, any time, including mid-operation):
  - pc_f=RESET_PC, queue empty, out_cnt=0, drop_cnt=0.
  - valid_d=0, InstrD=0, PCD=0, PCPlus4D=0, imem_req_valid=0.
- Request issue:
  - imem_req_valid = !redirect_valid && (q_count + out_cnt < FQ_DEPTH).
  - Handshake occurs when imem_req_valid && imem_req_ready.
  - On handshake: push pc_f into the pc FIFO, pc_f <= pc_f+4, out_cnt increments.
  - imem_req_addr is held stable while valid && !ready.
- Response:
  - On imem_rsp_valid with out_cnt>0: pop the pc FIFO head and decrement out_cnt.
  - If drop_cnt>0, discard the response and decrement drop_cnt.
  - Otherwise push {popped pc, imem_rsp_data} into the queue.
  - imem_rsp_valid with out_cnt==0 is ignored.
  - The credit rule guarantees the queue never overflows, so there is no response-ready signal.
- Output:
  - valid_d = queue non-empty. Outputs are combinational from the queue head; PCPlus4D = head pc + 4.
  - Data outputs are 0 when valid_d=0.
  - Head pops on valid_d && ready_d.
  - While ready_d=0 the outputs hold steady; fetch continues until credits run out.
- Redirect (redirect_valid=1):
  - Next cycle: pc_f <= {redirect_pc[XLEN-1:2],2'b00}.
  - Queue cleared; any same-cycle pop or push is overridden.
  - drop_cnt <= out_cnt + (handshake this cycle) - (response this cycle); no request is issued in the redirect cycle, so the handshake term is 0.
  - valid_d=0 the cycle after the redirect.
  - Redirect arriving while drop_cnt>0 accumulates per the same formula.
- Latency:
  - With 1-cycle memory, a request accepted in cycle N returns in N+1 and appears on valid_d in N+2.
  - Sustained throughput is 1 instruction/cycle with ready_d=1 and imem_req_ready=1.
- Counter arithmetic: pc_f wraps modulo 2^XLEN. Queue and FIFO pointers wrap modulo FQ_DEPTH.
- Simultaneous events in one cycle:
  - Push and pop in the same cycle leave q_count unchanged.
  - Response and request in the same cycle leave out_cnt unchanged.

Test Plan:
- Reset release, 1-cycle memory returning word 0x00100093+k at address k, ready_d=1:
  - valid_d rises 2 cycles after the first request.
  - PCD = 0,4,8,… on consecutive cycles; PCPlus4D = PCD+4.
- ready_d=0 for 10 cycles from PCD=0x8:
  - Outputs hold 0x8 and its instruction.
  - imem_req_valid falls once q_count + out_cnt = 4.
  - Stream resumes with 0xC and no loss or duplication.
- Redirect to 0x40 while 2 requests are outstanding:
  - The next 2 responses are discarded.
  - First valid_d after the redirect shows PCD=0x40.
  - No PC in 0xC–0x14 is delivered.
- Redirect with redirect_pc=0x43, in the same cycle as a pop and a response:
  - Queue empty the next cycle.
  - First delivered PCD=0x40.
- imem_req_ready randomly low and memory latency 3:
  - imem_req_addr holds stable while stalled.
  - Delivered PC sequence is contiguous.
  - Outstanding requests never exceed 4.
- rst asserted mid-stream with 3 outstanding:
  - All outputs are 0 immediately.
  - After release, spurious imem_rsp_valid pulses are ignored and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit: instruction fetch stage with a decoupling fetch queue.
//
// Requests instruction words from a latency-insensitive memory, tracks the PC
// of every outstanding request, and queues {pc, instr} pairs for decode.
// A redirect from decode flushes the queue, and the responses still in flight
// at that moment are counted and discarded when they return.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   redirect_valid  branch/jump redirect from decode
//   redirect_pc     redirect target (low two bits ignored)
//   imem_req_*      request handshake, imem_req_addr = word address of pc_f
//   imem_rsp_*      in-order responses, no backpressure
//   valid_d/ready_d head-of-queue handshake towards decode
//   InstrD/PCD/PCPlus4D  head entry, zero when valid_d is low
module fetch_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              IMEM_AW  = 8,
    parameter int              FQ_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [IMEM_AW-1:0] imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [31:0]        imem_rsp_data,
    output logic               valid_d,
    input  logic               ready_d,
    output logic [31:0]        InstrD,
    output logic [XLEN-1:0]    PCD,
    output logic [XLEN-1:0]    PCPlus4D
);

    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FQ_DEPTH);

    logic [XLEN-1:0] pc_f;

    // fetch queue
    logic [XLEN-1:0] q_pc    [FQ_DEPTH];
    logic [31:0]     q_instr [FQ_DEPTH];
    logic [PW-1:0]   q_wr, q_rd;
    logic [CW-1:0]   q_count;

    // PCs of outstanding requests; its occupancy is out_cnt
    logic [XLEN-1:0] f_pc [FQ_DEPTH];
    logic [PW-1:0]   f_wr, f_rd;
    logic [CW-1:0]   out_cnt;
    logic [CW-1:0]   drop_cnt;

    logic [CW:0]     credit_used;
    logic            hs;
    logic            rsp_fire;
    logic            rsp_keep;
    logic            pop;
    logic [XLEN-1:0] redirect_target;

    // Stale in-flight requests still hold a credit: their responses will
    // arrive and must be matched against the pc FIFO before being dropped.
    assign credit_used     = {1'b0, q_count} + {1'b0, out_cnt};
    assign imem_req_valid  = !rst && !redirect_valid && (credit_used < DEPTH_C);
    assign imem_req_addr   = pc_f[IMEM_AW+1:2];
    assign hs              = imem_req_valid && imem_req_ready;
    assign rsp_fire        = imem_rsp_valid && (out_cnt != '0);
    assign rsp_keep        = rsp_fire && (drop_cnt == '0);
    assign valid_d         = (q_count != '0);
    assign pop             = valid_d && ready_d;
    assign redirect_target = redirect_pc & ~XLEN'(3);

    assign InstrD   = valid_d ? q_instr[q_rd] : '0;
    assign PCD      = valid_d ? q_pc[q_rd] : '0;
    assign PCPlus4D = valid_d ? (q_pc[q_rd] + XLEN'(4)) : '0;

    // control state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f     <= RESET_PC;
            q_wr     <= '0;
            q_rd     <= '0;
            q_count  <= '0;
            f_wr     <= '0;
            f_rd     <= '0;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (hs) begin
                f_wr <= f_wr + PW'(1);
                pc_f <= pc_f + XLEN'(4);
            end
            if (redirect_valid)
                pc_f <= redirect_target;
            if (rsp_fire)
                f_rd <= f_rd + PW'(1);
            out_cnt <= out_cnt + CW'(hs) - CW'(rsp_fire);

            if (redirect_valid) begin
                // Everything still outstanding after this cycle becomes stale.
                q_wr     <= '0;
                q_rd     <= '0;
                q_count  <= '0;
                drop_cnt <= out_cnt + CW'(hs) - CW'(rsp_fire);
            end else begin
                if (rsp_keep)
                    q_wr <= q_wr + PW'(1);
                if (pop)
                    q_rd <= q_rd + PW'(1);
                q_count <= q_count + CW'(rsp_keep) - CW'(pop);
                if (rsp_fire && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    // storage; contents are only observed through valid entries
    always_ff @(posedge clk) begin
        if (hs)
            f_pc[f_wr] <= pc_f;
        if (rsp_keep && !redirect_valid) begin
            q_pc[q_wr]    <= f_pc[f_rd];
            q_instr[q_wr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int XLEN     = 64;
    localparam int IMEM_AW  = 8;
    localparam int FQ_DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [IMEM_AW-1:0] imem_req_addr;
    logic               imem_rsp_valid;
    logic [31:0]        imem_rsp_data;
    logic               valid_d;
    logic               ready_d;
    logic [31:0]        InstrD;
    logic [XLEN-1:0]    PCD;
    logic [XLEN-1:0]    PCPlus4D;

    fetch_unit #(
        .XLEN(XLEN), .RESET_PC('0), .IMEM_AW(IMEM_AW), .FQ_DEPTH(FQ_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .valid_d(valid_d), .ready_d(ready_d),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of_addr(logic [IMEM_AW-1:0] a);
        return 32'h00100093 + 32'(a);
    endfunction

    function automatic logic [31:0] word_of_pc(logic [XLEN-1:0] pc);
        logic [IMEM_AW-1:0] a;
        a = pc[IMEM_AW+1:2];
        return word_of_addr(a);
    endfunction

    // ---------------- scoreboard: expected delivery stream ----------------
    logic [XLEN-1:0] exp_q[$];
    int n_deliv = 0;

    task automatic sb_restart(logic [XLEN-1:0] start);
        exp_q.delete();
        for (int i = 0; i < 256; i++)
            exp_q.push_back(start + XLEN'(4 * i));
    endtask

    // monitor: a delivery happens when the head is consumed outside a redirect
    initial begin
        logic [XLEN-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && valid_d && ready_d && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got PCD %h expected no delivery", PCD);
                end else begin
                    e = exp_q.pop_front();
                    check("PCD", PCD, e);
                    check("InstrD", 64'(InstrD), 64'(word_of_pc(e)));
                    check("PCPlus4D", PCPlus4D, e + XLEN'(4));
                    n_deliv++;
                end
            end
        end
    end

    // ---------------- memory model: in-order, fixed latency ----------------
    logic [IMEM_AW-1:0] pend_addr[$];
    int                 pend_due[$];
    int                 latency  = 1;
    bit                 spurious = 1'b0;
    int                 max_pend = 0;

    initial begin
        logic               prev_stall;
        logic [IMEM_AW-1:0] prev_addr;
        logic [IMEM_AW-1:0] a;
        prev_stall = 1'b0;
        prev_addr  = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && pend_due.size() > 0 && pend_due[0] <= cyc) begin
                void'(pend_due.pop_front());
                a = pend_addr.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = word_of_addr(a);
            end else if (spurious) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = $urandom;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
            @(negedge clk);
            if (!rst) begin
                if (prev_stall && imem_req_valid)
                    check("addr_hold", 64'(imem_req_addr), 64'(prev_addr));
                if (imem_req_valid && imem_req_ready) begin
                    pend_addr.push_back(imem_req_addr);
                    pend_due.push_back(cyc + latency);
                end
                if (pend_addr.size() + (imem_rsp_valid ? 1 : 0) > max_pend)
                    max_pend = pend_addr.size() + (imem_rsp_valid ? 1 : 0);
                prev_stall = imem_req_valid && !imem_req_ready;
                prev_addr  = imem_req_addr;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    function automatic int outstanding();
        return pend_addr.size() + (imem_rsp_valid ? 1 : 0);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        int since;
        logic [XLEN-1:0] rpc;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        ready_d        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_d", 64'(valid_d), 0);
        check("rst_req_valid", 64'(imem_req_valid), 0);
        check("rst_PCD", PCD, 0);
        check("rst_InstrD", 64'(InstrD), 0);
        sb_restart('0);
        @(posedge clk);
        #2 rst = 1'b0;

        // first request -> valid_d two cycles later
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) found = 1;
        end
        check("first_req_seen", 64'(found), 1);
        @(negedge clk);
        check("lat_plus1_valid", 64'(valid_d), 0);
        @(negedge clk);
        check("lat_plus2_valid", 64'(valid_d), 1);
        check("lat_plus2_PCD", PCD, 0);

        // decode stall with 0x8 at the head
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #2;
            if (valid_d && PCD == 64'h8) found = 1;
        end
        check("stall_head_seen", 64'(found), 1);
        ready_d = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_PCD", PCD, 64'h8);
            check("stall_InstrD", 64'(InstrD), 64'(word_of_pc(64'h8)));
        end
        check("stall_credit_stop", 64'(imem_req_valid), 0);
        @(posedge clk);
        #2 ready_d = 1'b1;

        // redirect to 0x40 with two requests in flight
        latency = 3;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk);
            #2;
            if (outstanding() == 2) found = 1;
        end
        check("two_outstanding_seen", 64'(found), 1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        sb_restart(64'h40);
        @(posedge clk);
        #2 redirect_valid = 1'b0;
        check("redir_valid_next", 64'(valid_d), 0);
        repeat (20) @(posedge clk);

        // unaligned redirect coinciding with a pop and a response
        latency = 1;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk);
            #2;
            if (valid_d && ready_d && imem_rsp_valid) found = 1;
        end
        check("pop_rsp_cycle_seen", 64'(found), 1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h43;
        sb_restart(64'h40);
        @(posedge clk);
        #2 redirect_valid = 1'b0;
        check("flush_empty", 64'(valid_d), 0);
        repeat (20) @(posedge clk);

        // randomized: slow memory, request and decode backpressure, redirects
        latency = 3;
        since = 0;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #2;
            imem_req_ready = ($urandom_range(0, 3) != 0);
            ready_d        = ($urandom_range(0, 3) != 0);
            since++;
            if ($urandom_range(0, 24) == 0 || since > 120) begin
                rpc = {$urandom, $urandom};
                redirect_valid = 1'b1;
                redirect_pc    = rpc;
                sb_restart(rpc & ~64'h3);
                since = 0;
            end else begin
                redirect_valid = 1'b0;
            end
        end
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        ready_d        = 1'b1;

        // asynchronous reset with three requests in flight
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk);
            #2;
            if (outstanding() == 3) found = 1;
        end
        check("three_outstanding_seen", 64'(found), 1);
        #1 rst = 1'b1;
        pend_addr.delete();
        pend_due.delete();
        #1;
        check("amid_valid_d", 64'(valid_d), 0);
        check("amid_req_valid", 64'(imem_req_valid), 0);
        check("amid_PCD", PCD, 0);
        check("amid_PCPlus4D", PCPlus4D, 0);
        check("amid_InstrD", 64'(InstrD), 0);
        imem_req_ready = 1'b0;
        spurious       = 1'b1;
        sb_restart('0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("spurious_ignored", 64'(valid_d), 0);
        end
        @(posedge clk);
        #2 spurious = 1'b0;
        @(posedge clk);
        #2 imem_req_ready = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        check("restart_streaming", 64'(valid_d), 1);
        check("max_outstanding_ok", 64'(max_pend <= FQ_DEPTH), 1);
        check("enough_deliveries", 64'(n_deliv >= 200), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected end before 1ms");
        $fatal(1);
    end

endmodule
